if_pc_fetch: RTL and testbench
==============================

// Module: if_pc_fetch
// PURPOSE
//   Instruction-fetch stage fed by the 32-bit 4:1 next-PC select mux.
//   Holds the PC register, issues in-order requests to instruction memory, and buffers returned words.
//   Hands {inst, pc, pc+4} to decode over a valid/ready handshake.
//   id_pc4 returns to the mux as its sequential input (select 2'b00).
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC loaded on reset; bits[1:0] must be 0
//   FIFO_DEPTH  2              fetch-buffer entries, power of 2, >=2; also the max number of in-flight reads
// PORTS
//   clk          in   1   clock; all state updates on rising edge
//   rst          in   1   reset, synchronous, active-high
//   npc          in   32  target from next-PC mux; used only when redirect=1
//   redirect     in   1   taken branch/jump/jr this cycle (1-cycle pulse)
//   pc           out  32  address of the next request
//   imem_req     out  1   read request
//   imem_addr    out  32  = pc
//   imem_gnt     in   1   request accepted when imem_req&imem_gnt
//   imem_rvalid  in   1   response valid; responses return in request order, latency >=1
//   imem_rdata   in   32  instruction word
//   id_valid     out  1   head entry filled
//   id_ready     in   1   decode accepts; pop when id_valid&id_ready
//   id_inst      out  32  head instruction
//   id_pc        out  32  head PC
//   id_pc4       out  32  id_pc+4, mod 2^32
// BEHAVIOUR
//   Reset (rst=1 at edge): pc=RESET_PC, buffer empty, discard=0; while rst: imem_req=0, id_valid=0.
//   Buffer model: reservation FIFO. An entry {pc, inst, filled=0} is allocated at request handshake.
//     The fill pointer sets inst/filled on each kept imem_rvalid; pop at the head.
//   imem_req = !rst & !redirect & (alloc_cnt + discard < FIFO_DEPTH).
//   Handshake: pc <= pc+4, wrapping 32'hFFFF_FFFC -> 0.
//   No handshake: pc holds; imem_addr stable while imem_req is held.
//   Response: if discard>0, drop it and discard--; else fill the next unfilled entry. Fill-to-id_valid latency = 1 cycle.
//   Pop and allocate may coincide when full: count unchanged. Pop and fill may coincide when head is unfilled:
//     not possible, because pop needs head filled.
//   Redirect (priority over issue, fill and pop):
//     pc <= {npc[31:2],2'b00}; all entries flushed.
//     discard <= discard + (allocated-but-unfilled entries) - (rvalid this cycle ? 1 : 0); the response that
//       arrives in the redirect cycle is always dropped.
//     id_valid=0 on the following cycle.
//   Reset mid-operation: in-flight responses after rst are dropped via discard clear; the memory side is also reset
//     by the same rst.
//   Never issues an unaccounted request; buffer overflow is impossible by construction.
//   Outputs id_* come directly from the head entry, with no extra register stage.
// CONFIGURATION
//   IF_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] and perf_bubble[31:0], reset to 0.
//     perf_fetched counts pops; perf_bubble counts cycles with id_ready&!id_valid&!rst. Both wrap.
//   IF_PERF_CNT_EN undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//   Package if_pkg:
//     localparam INSN_BYTES=4; default RESET_PC constant;
//     typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst; logic filled;}.
//   Sub-module if_fetch_buf:
//     reservation FIFO with alloc/fill/pop/flush ports and head outputs.
//     alloc, fill and pop pointers are clog2(FIFO_DEPTH) wide; count is one bit wider.
//   Top level:
//     PC register, request gating, discard counter (clog2(FIFO_DEPTH+1) bits), optional perf counters.
// TESTING
//   1. Reset, gnt=1, rvalid 1 cycle after each grant, id_ready=1
//      -> id_pc sequence 0,4,8,...; id_pc4=id_pc+4; one pop per cycle in steady state.
//   2. id_ready=0 with DEPTH=2
//      -> exactly 2 grants, then imem_req=0 and pc=8; release -> pops of pc 0 and 4, then fetch resumes.
//   3. Two requests in flight (0,4), redirect with npc=32'h0000_0103
//      -> pc=32'h100; both late responses dropped; next id_pc=32'h100.
//   4. Redirect in the same cycle as rvalid and as id_ready&id_valid
//      -> no pop observed, response dropped, no request that cycle.
//   5. RESET_PC=32'hFFFF_FFF8
//      -> fetch FFFF_FFF8, FFFF_FFFC, 0; id_pc4 of FFFF_FFFC = 0.
//   6. rst asserted with 2 in flight, responses arrive after rst falls
//      -> id_valid stays 0 until the first post-reset fetch from RESET_PC.
//      With IF_PERF_CNT_EN also check counters are 0 after reset and perf_fetched=3 after 3 pops.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int INSN_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Reservation FIFO: an entry is allocated when a request is accepted and later
// filled in order by memory responses; the head is handed to decode once filled.
module if_fetch_buf
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         alloc,
  input  logic [31:0]  alloc_pc,
  input  logic         fill,
  input  logic [31:0]  fill_inst,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [CW-1:0] count,
  output logic [CW-1:0] unfilled
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] pop_ptr;

  assign head       = mem[pop_ptr];
  assign head_valid = (count != '0) && mem[pop_ptr].filled;

  // Filled entries are contiguous from the head, so equal alloc/fill pointers
  // mean either "nothing unfilled" or "full and nothing filled yet".
  always_comb begin
    unfilled = {1'b0, alloc_ptr - fill_ptr};
    if (alloc_ptr == fill_ptr) begin
      unfilled = ((count == CW'(DEPTH)) && !mem[pop_ptr].filled) ? CW'(DEPTH) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
      count     <= '0;
    end else begin
      if (alloc) begin
        mem[alloc_ptr] <= '{pc: alloc_pc, inst: 32'h0, filled: 1'b0};
        alloc_ptr      <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        mem[fill_ptr].inst   <= fill_inst;
        mem[fill_ptr].filled <= 1'b1;
        fill_ptr             <= fill_ptr + 1'b1;
      end
      if (pop) begin
        pop_ptr <= pop_ptr + 1'b1;
      end
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

endmodule

// File: rtl/if_pc_fetch.sv
// Instruction-fetch stage: PC register, in-order imem requests, reservation buffer.
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_bubble counters.
module if_pc_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        redirect,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubble
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(FIFO_DEPTH + 1);

  // Handshakes: a transfer happens on a rising edge where valid (imem_req /
  // id_valid) and ready (imem_gnt / id_ready) are both high; valid never waits on ready.
  fetch_entry_t  head;
  logic          head_valid;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] buf_unfilled;
  logic [DW-1:0] discard;
  logic [CW:0]   outstanding;
  logic          grant;
  logic          fill;
  logic          drop_resp;
  logic          pop;
  logic [DW:0]   discard_redir;

  assign outstanding = {1'b0, buf_count} + (CW + 1)'(discard);
  assign imem_req    = !rst && !redirect && (outstanding < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr   = pc;
  assign grant       = imem_req && imem_gnt;
  assign fill        = imem_rvalid && !rst && !redirect && (discard == '0) && (buf_unfilled != '0);
  assign drop_resp   = imem_rvalid && !redirect && (discard != '0);
  assign id_valid    = head_valid && !rst;
  assign pop         = id_valid && id_ready && !redirect;

  assign id_inst = head.inst;
  assign id_pc   = head.pc;
  assign id_pc4  = head.pc + 32'(INSN_BYTES);

  // Every live-but-unfilled request becomes a stale response to drop; the one
  // arriving during the redirect cycle is consumed right away.
  always_comb begin
    discard_redir = (DW + 1)'(discard) + (DW + 1)'(buf_unfilled);
    if (imem_rvalid && (discard_redir != '0)) begin
      discard_redir = discard_redir - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      discard <= '0;
    end else if (redirect) begin
      pc      <= {npc[31:2], 2'b00};
      discard <= DW'(discard_redir);
    end else begin
      if (grant) begin
        pc <= pc + 32'(INSN_BYTES);
      end
      if (drop_resp) begin
        discard <= discard - 1'b1;
      end
    end
  end

  if_fetch_buf #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .alloc     (grant),
    .alloc_pc  (pc),
    .fill      (fill),
    .fill_inst (imem_rdata),
    .pop       (pop),
    .head      (head),
    .head_valid(head_valid),
    .count     (buf_count),
    .unfilled  (buf_unfilled)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubble  <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (id_ready && !id_valid) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_pc_fetch.sv
// Randomized bench for if_pc_fetch with an in-order memory model and a
// request/response-level reference model of the fetch stream.
module tb_if_pc_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        redirect;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  if_pc_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .redirect   (redirect),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubble (perf_bubble)
`endif
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit post_rst = 1'b0;

  // memory environment: in-order responses with a due cycle each
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due = 0;

  // reference model: live requests in issue order (exp_q), how many of the
  // oldest have returned, and how many stale responses are still in flight
  logic [31:0] exp_q[$];
  int          live_ret = 0;
  int          stale    = 0;
  logic [31:0] issue_pc = RST_PC;
  int          m_fetched = 0;
  int          m_bubble  = 0;
  int          n_pops    = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check and advance the
  // model at the falling edge, then wait for the next rising edge.
  task automatic step(input logic r, input logic red, input logic [31:0] n,
                      input logic g, input logic rdy, input int lat);
    logic rv;
    logic ghost;
    logic exp_req;
    logic exp_valid;
    logic do_pop;
    int   due;
    rst      = r;
    redirect = red;
    npc      = n;
    imem_gnt = g;
    id_ready = rdy;
    if (r) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      last_due = 0;
    end
    rv    = !r && (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
    ghost = !r && post_rst && !g && !red && (mem_addr_q.size() == 0);
    imem_rvalid = rv || ghost;
    imem_rdata  = rv ? word_of(mem_addr_q[0]) : (ghost ? 32'hDEAD_BEEF : $urandom);
    @(negedge clk);

    exp_req   = !r && !red && ((exp_q.size() + stale) < DEPTH);
    exp_valid = !r && (live_ret > 0);
    check("imem_req", imem_req, exp_req);
    check("id_valid", id_valid, exp_valid);
    if (!r) begin
      check("pc", pc, issue_pc);
      check("imem_addr", imem_addr, issue_pc);
`ifdef IF_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_bubble", perf_bubble, m_bubble);
`endif
    end
    if (exp_valid) begin
      check("id_pc", id_pc, exp_q[0]);
      check("id_inst", id_inst, word_of(exp_q[0]));
      check("id_pc4", id_pc4, exp_q[0] + 32'd4);
    end

    // memory side reacts to what the DUT actually drives
    if (rv) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (!r && imem_req && imem_gnt) begin
      due = cyc + $urandom_range(1, lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(due);
    end

    // reference model update for the coming edge
    if (r) begin
      exp_q.delete();
      live_ret  = 0;
      stale     = 0;
      issue_pc  = RST_PC;
      m_fetched = 0;
      m_bubble  = 0;
    end else begin
      if (rdy && !exp_valid) m_bubble++;
      if (red) begin
        stale = stale + (exp_q.size() - live_ret) - ((rv || ghost) ? 1 : 0);
        if (stale < 0) stale = 0;
        exp_q.delete();
        live_ret = 0;
        issue_pc = {n[31:2], 2'b00};
      end else begin
        do_pop = exp_valid && rdy;
        if (rv || ghost) begin
          if (stale > 0) stale--;
          else if (live_ret < exp_q.size()) live_ret++;
        end
        if (do_pop) begin
          void'(exp_q.pop_front());
          live_ret--;
          m_fetched++;
          n_pops++;
        end
        if (exp_req && g) begin
          exp_q.push_back(issue_pc);
          issue_pc = issue_pc + 32'd4;
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    post_rst = r;
  endtask

  function automatic logic [31:0] pick_npc();
    case ($urandom_range(0, 3))
      0: return 32'h0000_0103;
      1: return 32'hFFFF_FFFE;
      2: return 32'h0000_1000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; redirect = 1'b0; npc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // streaming: gnt=1, 1-cycle latency, decode always ready (wraps past 0)
    repeat (30) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // decode stalls: buffer fills, requests stop; then release
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // two slow requests in flight, then a redirect to 0x103
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b1, 4);
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // redirect while a filled head is offered and a response arrives
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    step(1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b1, 1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // reset with requests in flight; a leftover response right after reset
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3);
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 7) == 0),
           pick_npc(),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(1, 3));
    end

    check("stream_progress", (n_pops > 200), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
